intack_sequencer: RTL and testbench
===================================

// Module: intack_sequencer
// PURPOSE
//  CPU-side initiator of the 8259A interrupt-acknowledge protocol; drives the INTA_n pin our PIC responds to.
//  Detects INT while the CPU interrupt flag is set, issues the INTA_n pulse train, and captures the vector bytes from the data bus.
//  Hands the result to the CPU core with a valid/ack handshake.
//  Supports 8086 mode (2 pulses, vector on pulse 2) and 8080 mode (3 pulses, CALL opcode plus 16-bit address).
// PARAMETERS
//  PULSE_LOW_CYCLES  2  clk cycles INTA_n is held low per pulse (>=1)
//  GAP_CYCLES        2  clk cycles INTA_n is held high between pulses (>=1)
//  INT_SYNC_STAGES   2  synchronizer flops on INT (>=2)
// PORTS
//  clk           in   1   system clock; all logic on posedge
//  reset_n       in   1   asynchronous, active-low reset
//  INT           in   1   interrupt request from PIC (asynchronous)
//  int_enable    in   1   CPU interrupt flag; a sequence starts only when it is 1
//  mode_8080     in   1   1 = 3-pulse MCS-80 sequence, 0 = 2-pulse 8086 sequence
//  data_bus      in   8   PIC data bus, sampled during INTA_n low
//  vector_ack    in   1   core accepts vector_out / call_addr
//  INTA_n        out  1   acknowledge strobe to PIC, registered
//  busy          out  1   high from leaving IDLE until vector accepted
//  vector_valid  out  1   vector_out / call_addr hold valid data
//  vector_out    out  8   8086 vector byte (pulse 2)
//  call_addr     out  16  8080 CALL target {pulse3 byte, pulse2 byte}
//  opcode_err    out  1   8080 mode: pulse-1 byte != 8'hCD; sticky until next sequence start
// BEHAVIOUR
//  Reset: INTA_n=1, busy=0, vector_valid=0, vector_out=0, call_addr=0, opcode_err=0, FSM=IDLE. All outputs registered.
//  INT passes through INT_SYNC_STAGES flops -> int_s. Latency from INT rise to first INTA_n fall = INT_SYNC_STAGES+1 clk.
//  mode_8080 is latched into mode_q on IDLE->P_LOW. Later changes to mode_8080 are ignored until the next sequence.
//  States (shared cnt counts down; pulse index idx in 1..3):
//   IDLE   : if int_s & int_enable -> P_LOW; idx=1; cnt=PULSE_LOW_CYCLES-1; INTA_n<=0; busy<=1; opcode_err<=0.
//   P_LOW  : INTA_n=0. When cnt==0, sample data_bus into byte[idx] on that same edge.
//            Then, if idx==last (2, or 3 when mode_q) -> DONE; else -> P_GAP with cnt=GAP_CYCLES-1 and INTA_n<=1.
//   P_GAP  : INTA_n=1. When cnt==0 -> P_LOW with idx+1, cnt=PULSE_LOW_CYCLES-1, INTA_n<=0.
//   DONE   : INTA_n=1, vector_valid=1, outputs stable. When vector_ack -> IDLE with vector_valid<=0 and busy<=0.
//  On entry to DONE (8086 mode): vector_out=byte2; call_addr is unchanged.
//  On entry to DONE (8080 mode): call_addr={byte3,byte2}; opcode_err=(byte1!=8'hCD).
//  In 8086 mode byte1 is a don't-care and is discarded.
//  Boundaries:
//   - INT drops before leaving IDLE: no pulse issued.
//   - INT drops or int_enable clears after the first INTA_n fall: sequence runs to completion (PIC supplies its IR7 spurious vector).
//   - vector_ack low in DONE: remain in DONE indefinitely. vector_ack while not in DONE: ignored.
//   - INT high during DONE or on the cycle of the IDLE return: no restart until the FSM is in IDLE. Minimum one IDLE cycle between sequences.
//   - reset_n low mid-pulse: INTA_n returns to 1 asynchronously and all state clears.
// CONFIGURATION
//  INTACK_LOCK_EN defined:
//   - adds output lock_n (1b, reset 1).
//   - lock_n<=0 on the same edge as the first INTA_n fall; lock_n<=1 on the edge INTA_n rises after the last pulse.
//   - lock_n is asserted across the inter-pulse gaps.
//  INTACK_LOCK_EN undefined: port lock_n and its logic are absent. All other behaviour is identical.
// STRUCTURE
//  Shared package pic_pkg:
//   - FSM state encoding localparams (IDLE, P_LOW, P_GAP, DONE).
//   - CALL_OPCODE = 8'hCD.
//   - pulse-count localparams N_PULSES_8086 = 2 and N_PULSES_8080 = 3.
//  Sub-module pic_sync (N-stage flop synchronizer, parameter STAGES) instantiated for INT.
//  Reused by the PIC's own input path. Everything else lives in this module.
// TESTING
//  1. 8086 mode, defaults:
//     - stimulus: INT=1, int_enable=1; data_bus=8'h4A during pulse 2.
//     - response: two INTA_n lows of 2 clk with a 2 clk gap; first fall 3 clk after INT; vector_out=8'h4A and vector_valid=1 after pulse 2.
//  2. 8080 mode:
//     - stimulus: data_bus 8'hCD / 8'h34 / 8'h12 on pulses 1/2/3.
//     - response: 3 pulses; call_addr=16'h1234; opcode_err=0. Repeat with byte1=8'hC3 -> opcode_err=1.
//  3. int_enable=0 with INT=1 for 20 clk -> INTA_n stays 1, busy=0. Raise int_enable -> sequence starts 1 clk later.
//  4. Edge cases:
//     - INT drops during the pulse-1 low -> both pulses still issued, vector_valid=1.
//     - vector_ack held 0 for 10 clk -> state held, INTA_n=1.
//     - ack while INT is still high -> one IDLE cycle, then a new sequence.
//  5. reset_n pulsed low during the pulse-2 low -> INTA_n=1 immediately; all outputs at reset values; a new sequence runs normally after release.
//  6. Built with INTACK_LOCK_EN: lock_n low continuously from the first INTA_n fall to the last INTA_n rise in both modes. Without it: port absent (elaboration check).

Source files
------------

// File: rtl/pic_pkg.sv
// pic_pkg: shared FSM encoding and protocol constants for the interrupt-acknowledge sequencer
package pic_pkg;
  typedef enum logic [1:0] {IDLE, P_LOW, P_GAP, DONE} state_t;
  localparam logic [7:0] CALL_OPCODE   = 8'hCD;
  localparam logic [1:0] N_PULSES_8086 = 2'd2;
  localparam logic [1:0] N_PULSES_8080 = 2'd3;
  function automatic logic [1:0] last_pulse(input logic m8080);
    return m8080 ? N_PULSES_8080 : N_PULSES_8086;
  endfunction
endpackage

// File: rtl/pic_sync.sv
// pic_sync: N-stage flop synchronizer for asynchronous single-bit inputs
module pic_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic q_o
);
  logic [STAGES-1:0] ff_q;
  // shift the input through the synchronizer chain
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) ff_q <= '0;
    else ff_q <= {ff_q[STAGES-2:0], d_i};
  assign q_o = ff_q[STAGES-1];
endmodule

// File: rtl/intack_sequencer.sv
// intack_sequencer: drives the 8259A INTA_n pulse train and captures vector bytes; define INTACK_LOCK_EN to add the lock_n output
module intack_sequencer
  import pic_pkg::*;
#(
  parameter int PULSE_LOW_CYCLES = 2,
  parameter int GAP_CYCLES       = 2,
  parameter int INT_SYNC_STAGES  = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        INT,
  input  logic        int_enable,
  input  logic        mode_8080,
  input  logic [7:0]  data_bus,
  input  logic        vector_ack,
  output logic        INTA_n,
  output logic        busy,
  output logic        vector_valid,
  output logic [7:0]  vector_out,
  output logic [15:0] call_addr,
`ifdef INTACK_LOCK_EN
  output logic        lock_n,
`endif
  output logic        opcode_err
);
  localparam int CMAX = PULSE_LOW_CYCLES > GAP_CYCLES ? PULSE_LOW_CYCLES : GAP_CYCLES;
  localparam int CW = CMAX > 1 ? $clog2(CMAX) : 1;
  localparam logic [CW-1:0] PL_RLD  = CW'(PULSE_LOW_CYCLES - 1);
  localparam logic [CW-1:0] GAP_RLD = CW'(GAP_CYCLES - 1);
  logic int_s;
  state_t state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic mode_q, mode_d;
  logic [7:0] b1_q, b1_d, b2_q, b2_d;
  logic inta_q, inta_d, busy_q, busy_d, valid_q, valid_d, err_q, err_d;
  logic [7:0] vec_q, vec_d;
  logic [15:0] call_q, call_d;
`ifdef INTACK_LOCK_EN
  logic lock_q, lock_d;
  assign lock_n = lock_q;
`endif
  pic_sync #(.STAGES(INT_SYNC_STAGES)) u_int_sync (
    .clk    (clk),
    .reset_n(reset_n),
    .d_i    (INT),
    .q_o    (int_s)
  );
  // state and output registers; reset forces INTA_n high immediately
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      b1_q    <= '0;
      b2_q    <= '0;
      inta_q  <= 1'b1;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      vec_q   <= '0;
      call_q  <= '0;
`ifdef INTACK_LOCK_EN
      lock_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      b1_q    <= b1_d;
      b2_q    <= b2_d;
      inta_q  <= inta_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      vec_q   <= vec_d;
      call_q  <= call_d;
`ifdef INTACK_LOCK_EN
      lock_q  <= lock_d;
`endif
    end
  // pulse sequencing: low phase samples the bus on its final cycle, gap phase spaces the pulses
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    b1_d    = b1_q;
    b2_d    = b2_q;
    inta_d  = inta_q;
    busy_d  = busy_q;
    valid_d = valid_q;
    err_d   = err_q;
    vec_d   = vec_q;
    call_d  = call_q;
`ifdef INTACK_LOCK_EN
    lock_d  = lock_q;
`endif
    case (state_q)
      IDLE: if (int_s && int_enable) begin
        state_d = P_LOW;
        idx_d   = 2'd1;
        cnt_d   = PL_RLD;
        mode_d  = mode_8080;
        inta_d  = 1'b0;
        busy_d  = 1'b1;
        err_d   = 1'b0;
`ifdef INTACK_LOCK_EN
        lock_d  = 1'b0;
`endif
      end
      P_LOW: if (cnt_q == '0) begin
        b1_d   = idx_q == 2'd1 ? data_bus : b1_q;
        b2_d   = idx_q == 2'd2 ? data_bus : b2_q;
        inta_d = 1'b1;
        if (idx_q == last_pulse(mode_q)) begin
          state_d = DONE;
          valid_d = 1'b1;
          vec_d   = mode_q ? vec_q : data_bus;
          call_d  = mode_q ? {data_bus, b2_q} : call_q;
          err_d   = mode_q ? (b1_q != CALL_OPCODE) : err_q;
`ifdef INTACK_LOCK_EN
          lock_d  = 1'b1;
`endif
        end else begin
          state_d = P_GAP;
          cnt_d   = GAP_RLD;
        end
      end else cnt_d = cnt_q - 1'b1;
      P_GAP: if (cnt_q == '0) begin
        state_d = P_LOW;
        idx_d   = idx_q + 2'd1;
        cnt_d   = PL_RLD;
        inta_d  = 1'b0;
      end else cnt_d = cnt_q - 1'b1;
      DONE: if (vector_ack) begin
        state_d = IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  assign INTA_n       = inta_q;
  assign busy         = busy_q;
  assign vector_valid = valid_q;
  assign vector_out   = vec_q;
  assign call_addr    = call_q;
  assign opcode_err   = err_q;
endmodule

// File: tb/tb_intack_sequencer.sv
// tb_intack_sequencer: directed-vector bench for the interrupt-acknowledge sequencer (default build)
module tb_intack_sequencer;
  logic clk = 1'b0, reset_n = 1'b0, INT = 1'b0, int_enable = 1'b0, mode_8080 = 1'b0, vector_ack = 1'b0;
  logic [7:0] data_bus = 8'h00;
  logic INTA_n, busy, vector_valid, opcode_err;
  logic [7:0] vector_out;
  logic [15:0] call_addr;
  int nvec = 0, nerr = 0, pc = 0;
  logic [7:0] pat [1:3];

  always #5 clk = ~clk;

  intack_sequencer dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .INT         (INT),
    .int_enable  (int_enable),
    .mode_8080   (mode_8080),
    .data_bus    (data_bus),
    .vector_ack  (vector_ack),
    .INTA_n      (INTA_n),
    .busy        (busy),
    .vector_valid(vector_valid),
    .vector_out  (vector_out),
    .call_addr   (call_addr),
    .opcode_err  (opcode_err)
  );

  // PIC model: presents the next byte of the pattern on each INTA_n fall
  always @(negedge INTA_n) begin
    pc = pc + 1;
    data_bus = (pc >= 1 && pc <= 3) ? pat[pc] : 8'h00;
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic arm(input logic m, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    pat[1] = a;
    pat[2] = b;
    pat[3] = c;
    pc = 0;
    mode_8080 = m;
    int_enable = 1'b1;
    INT = 1'b1;
  endtask

  task automatic capture(input int n, output logic [15:0] w);
    w = '0;
    for (int i = 0; i < n; i++) begin
      step(1);
      w = {w[14:0], INTA_n};
    end
  endtask

  task automatic retire();
    int k;
    INT = 1'b0;
    k = 0;
    while (!vector_valid && k < 40) begin
      step(1);
      k++;
    end
    check("done_reached", {15'd0, vector_valid}, 16'd1);
    step(3);
    vector_ack = 1'b1;
    step(1);
    vector_ack = 1'b0;
    check("ack_clears_valid", {15'd0, vector_valid}, 16'd0);
  endtask

  initial begin
    logic [15:0] w, w1, w2;
    logic hi;
    step(3);
    check("rst_inta", {15'd0, INTA_n}, 16'd1);
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_valid", {15'd0, vector_valid}, 16'd0);
    check("rst_vector", {8'd0, vector_out}, 16'd0);
    check("rst_call", call_addr, 16'd0);
    check("rst_err", {15'd0, opcode_err}, 16'd0);
    reset_n = 1'b1;
    step(2);

    arm(1'b0, 8'h11, 8'h4A, 8'h22);
    capture(4, w1);
    mode_8080 = 1'b1;
    capture(6, w2);
    check("t1_wave", {6'd0, w1[3:0], w2[5:0]}, 16'h0333);
    check("t1_vector", {8'd0, vector_out}, 16'h004A);
    check("t1_valid", {15'd0, vector_valid}, 16'd1);
    check("t1_busy", {15'd0, busy}, 16'd1);
    check("t1_call_kept", call_addr, 16'd0);

    hi = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      hi = hi & INTA_n & vector_valid & busy;
    end
    check("hold_done", {15'd0, hi}, 16'd1);

    pat[2] = 8'h77;
    pc = 0;
    mode_8080 = 1'b0;
    vector_ack = 1'b1;
    step(1);
    vector_ack = 1'b0;
    check("idle_valid", {15'd0, vector_valid}, 16'd0);
    check("idle_busy", {15'd0, busy}, 16'd0);
    check("idle_inta", {15'd0, INTA_n}, 16'd1);
    step(1);
    check("restart_inta", {15'd0, INTA_n}, 16'd0);
    check("restart_busy", {15'd0, busy}, 16'd1);
    retire();
    check("restart_vector", {8'd0, vector_out}, 16'h0077);
    step(2);

    arm(1'b1, 8'hCD, 8'h34, 8'h12);
    capture(14, w);
    check("t2_wave", w, 16'h3333);
    check("t2_call", call_addr, 16'h1234);
    check("t2_err", {15'd0, opcode_err}, 16'd0);
    check("t2_vector_kept", {8'd0, vector_out}, 16'h0077);
    retire();
    step(2);
    arm(1'b1, 8'hC3, 8'h56, 8'h78);
    capture(14, w);
    check("t2b_call", call_addr, 16'h7856);
    check("t2b_err", {15'd0, opcode_err}, 16'd1);
    retire();
    check("err_sticky", {15'd0, opcode_err}, 16'd1);
    step(2);

    pat[1] = 8'h00;
    pat[2] = 8'h5C;
    pat[3] = 8'h00;
    pc = 0;
    mode_8080 = 1'b0;
    int_enable = 1'b0;
    INT = 1'b1;
    hi = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      hi = hi & INTA_n & !busy;
    end
    check("disabled_idle", {15'd0, hi}, 16'd1);
    int_enable = 1'b1;
    step(1);
    check("enable_start", {15'd0, INTA_n}, 16'd0);
    check("err_cleared", {15'd0, opcode_err}, 16'd0);
    int_enable = 1'b0;
    retire();
    check("late_drop_vector", {8'd0, vector_out}, 16'h005C);
    step(2);

    int_enable = 1'b1;
    @(posedge clk);
    #2 INT = 1'b1;
    #3 INT = 1'b0;
    hi = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      hi = hi & INTA_n & !busy;
    end
    check("glitch_ignored", {15'd0, hi}, 16'd1);

    arm(1'b0, 8'h11, 8'h99, 8'h22);
    step(7);
    check("p2_low", {15'd0, INTA_n}, 16'd0);
    #2 reset_n = 1'b0;
    #1;
    check("async_inta", {15'd0, INTA_n}, 16'd1);
    check("async_busy", {15'd0, busy}, 16'd0);
    check("async_vector", {8'd0, vector_out}, 16'd0);
    check("async_call", call_addr, 16'd0);
    INT = 1'b0;
    step(2);
    reset_n = 1'b1;
    step(2);
    arm(1'b0, 8'h11, 8'h3E, 8'h22);
    capture(10, w);
    check("post_rst_wave", w, 16'h0333);
    check("post_rst_vector", {8'd0, vector_out}, 16'h003E);
    retire();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
